// File: rtl/xor_stream_cipher.sv
// Handshaked keyed stream cipher: a Galois LFSR seeded from a loaded key supplies
// DATA_W keystream bits per accepted beat, XORed onto the data (encrypt == decrypt).
module xor_stream_cipher #(
  parameter int unsigned      DATA_W  = 8,
  parameter int unsigned      KEY_W   = 16,
  parameter logic [KEY_W-1:0] TAPS    = 16'hB400,
  parameter int unsigned      REKEY_N = 0,
  parameter int unsigned      CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_key,
  input  logic [KEY_W-1:0]  key,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              key_valid,
  output logic              rekey_req,
  output logic [CNT_W-1:0]  beat_cnt
);

  typedef enum logic [1:0] {
    NOKEY,
    RUN,
    EXHAUSTED
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [KEY_W-1:0]  r_lfsr;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [CNT_W-1:0]  r_beat_cnt;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [KEY_W-1:0]  w_seed;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_limit_hit;

  function automatic logic [KEY_W-1:0] f_advance(input logic [KEY_W-1:0] l);
    logic [KEY_W-1:0] v;
    v = l;
    for (int unsigned i = 0; i < DATA_W; i++)
      v = v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
    return v;
  endfunction

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  assign w_seed      = (key == '0) ? KEY_W'(1) : key;
  assign w_in_ready  = (r_state == RUN) && !load_key && (!r_out_valid || out_ready);
  assign w_accept    = in_valid && w_in_ready;
  assign w_cnt_inc   = (&r_beat_cnt) ? r_beat_cnt : r_beat_cnt + CNT_W'(1);
  assign w_limit_hit = (REKEY_N != 0) && (w_cnt_inc == CNT_W'(REKEY_N));

  always_comb begin
    w_state_nxt = r_state;
    if (load_key)
      w_state_nxt = RUN;
    else if (r_state == RUN && w_accept && w_limit_hit)
      w_state_nxt = EXHAUSTED;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_state <= NOKEY;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr      <= KEY_W'(1);
      r_beat_cnt  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (load_key) begin
        r_lfsr     <= w_seed;
        r_beat_cnt <= '0;
      end else if (w_accept) begin
        r_lfsr     <= f_advance(r_lfsr);
        r_beat_cnt <= w_cnt_inc;
      end
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= in_data ^ r_lfsr[DATA_W-1:0];
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign key_valid = (r_state == RUN);
  assign rekey_req = (r_state == EXHAUSTED);
  assign beat_cnt  = r_beat_cnt;

endmodule
